// File: rtl/nn_ctrl_pkg.sv
// Shared types for the multi-layer NN sequencer: FSM states and pass mode.
package nn_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      FWD,
      BWD,
      UPDATE,
      DISPLAY
   } seq_state_t;

   typedef enum logic {
      MODE_INFER,
      MODE_TRAIN
   } seq_mode_t;

endpackage

// File: rtl/nn_start_queue.sv
// One-deep holding register for a start request that arrives while a pass is running.
module nn_start_queue
   import nn_ctrl_pkg::*;
#(
   parameter int unsigned IMG_SZ = 784 << 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  seq_mode_t         i_mode,
   input  logic [IMG_SZ-1:0] i_image,
   input  logic              i_busy,
   output logic              o_pending,
   output seq_mode_t         o_mode,
   output logic [IMG_SZ-1:0] o_image,
   output logic              o_overrun
);

   logic              r_pend;
   seq_mode_t         r_mode;
   logic [IMG_SZ-1:0] r_image;
   logic              r_overrun;
   logic              w_push;
   logic              w_pop;

   assign w_push = i_start & (i_busy | r_pend);
   assign w_pop  = ~i_busy & r_pend;

   // A pop and a push in the same cycle leave the slot full with the new request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend    <= 1'b0;
         r_mode    <= MODE_INFER;
         r_image   <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= w_push & r_pend & ~w_pop;
         if (w_push & (~r_pend | w_pop)) begin
            r_pend  <= 1'b1;
            r_mode  <= i_mode;
            r_image <= i_image;
         end else if (w_pop) begin
            r_pend <= 1'b0;
         end
      end
   end

   assign o_pending = r_pend;
   assign o_mode    = r_mode;
   assign o_image   = r_image;
   assign o_overrun = r_overrun;

endmodule

// File: rtl/nn_layer_sequencer.sv
// Multi-layer, mini-batch NN controller: weight load, forward/backward per layer,
// batched update and display, with a one-deep start queue and abort.
module nn_layer_sequencer
   import nn_ctrl_pkg::*;
#(
   parameter  int unsigned IMG_SZ     = 784 << 3,
   parameter  int unsigned NUM_LAYERS = 3,
   parameter  int unsigned BATCH_SZ   = 8,
   localparam int unsigned LW = ($clog2(NUM_LAYERS) > 1) ? $clog2(NUM_LAYERS) : 1,
   localparam int unsigned CW = $clog2(BATCH_SZ + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              train,
   input  logic              abort,
   input  logic [IMG_SZ-1:0] image_in,
   input  logic              weights_ack,
   input  logic              fp_done,
   input  logic              bp_done,
   input  logic              upd_done,
   input  logic              drawn,
   output logic              get_weights,
   output logic              fp_go,
   output logic              bp_go,
   output logic              upd_go,
   output logic              draw,
   output logic [LW-1:0]     layer_idx,
   output logic [CW-1:0]     sample_cnt,
   output logic              busy,
   output logic              overrun,
   output logic [IMG_SZ-1:0] image_out
);

   localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);

   seq_state_t        r_state, w_state_nxt;
   seq_mode_t         r_mode;
   logic              r_wvalid, w_wvalid_nxt;
   logic [LW-1:0]     r_layer, w_layer_nxt;
   logic [CW-1:0]     r_cnt, w_cnt_nxt;
   logic              r_fp_go, r_bp_go, r_upd_go;
   logic              w_fp_go_nxt, w_bp_go_nxt, w_upd_go_nxt;
   logic [IMG_SZ-1:0] r_image;

   logic              w_busy;
   logic              w_pending;
   seq_mode_t         w_q_mode;
   logic [IMG_SZ-1:0] w_q_image;
   logic              w_accept;
   seq_mode_t         w_acc_mode;
   logic [IMG_SZ-1:0] w_acc_image;
   logic [CW-1:0]     w_cnt_inc;

   nn_start_queue #(
      .IMG_SZ (IMG_SZ)
   ) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_start   (start),
      .i_mode    (seq_mode_t'(train)),
      .i_image   (image_in),
      .i_busy    (w_busy),
      .o_pending (w_pending),
      .o_mode    (w_q_mode),
      .o_image   (w_q_image),
      .o_overrun (overrun)
   );

   assign w_busy      = (r_state != IDLE);
   assign w_accept    = ~w_busy & (start | w_pending);
   assign w_acc_mode  = w_pending ? w_q_mode  : seq_mode_t'(train);
   assign w_acc_image = w_pending ? w_q_image : image_in;
   assign w_cnt_inc   = r_cnt + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_mode   <= MODE_INFER;
         r_wvalid <= 1'b0;
         r_layer  <= '0;
         r_cnt    <= '0;
         r_fp_go  <= 1'b0;
         r_bp_go  <= 1'b0;
         r_upd_go <= 1'b0;
         r_image  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_wvalid <= w_wvalid_nxt;
         r_layer  <= w_layer_nxt;
         r_cnt    <= w_cnt_nxt;
         r_fp_go  <= w_fp_go_nxt;
         r_bp_go  <= w_bp_go_nxt;
         r_upd_go <= w_upd_go_nxt;
         if (w_accept) begin
            r_mode  <= w_acc_mode;
            r_image <= w_acc_image;
         end
      end
   end

   // Go pulses are registered, so each appears the cycle after its triggering done.
   always_comb begin
      w_state_nxt  = r_state;
      w_wvalid_nxt = r_wvalid;
      w_layer_nxt  = r_layer;
      w_cnt_nxt    = r_cnt;
      w_fp_go_nxt  = 1'b0;
      w_bp_go_nxt  = 1'b0;
      w_upd_go_nxt = 1'b0;
      if (abort && w_busy) begin
         w_state_nxt = IDLE;
         w_layer_nxt = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  w_layer_nxt = '0;
                  if (!r_wvalid) begin
                     w_state_nxt = LOAD_W;
                  end else begin
                     w_state_nxt = FWD;
                     w_fp_go_nxt = 1'b1;
                  end
               end
            end
            LOAD_W: begin
               if (weights_ack) begin
                  w_wvalid_nxt = 1'b1;
                  w_state_nxt  = FWD;
                  w_layer_nxt  = '0;
                  w_fp_go_nxt  = 1'b1;
               end
            end
            FWD: begin
               if (fp_done) begin
                  if (r_layer != LAST_LAYER) begin
                     w_layer_nxt = r_layer + 1'b1;
                     w_fp_go_nxt = 1'b1;
                  end else if (r_mode == MODE_TRAIN) begin
                     w_state_nxt = BWD;
                     w_bp_go_nxt = 1'b1;
                  end else begin
                     w_state_nxt = DISPLAY;
                  end
               end
            end
            BWD: begin
               if (bp_done) begin
                  if (r_layer != '0) begin
                     w_layer_nxt = r_layer - 1'b1;
                     w_bp_go_nxt = 1'b1;
                  end else begin
                     w_cnt_nxt = w_cnt_inc;
                     if (w_cnt_inc == CW'(BATCH_SZ)) begin
                        w_state_nxt  = UPDATE;
                        w_upd_go_nxt = 1'b1;
                     end else begin
                        w_state_nxt = IDLE;
                     end
                  end
               end
            end
            UPDATE: begin
               if (upd_done) begin
                  w_cnt_nxt    = '0;
                  w_wvalid_nxt = 1'b0;
                  w_state_nxt  = IDLE;
               end
            end
            DISPLAY: begin
               if (drawn) begin
                  w_state_nxt = IDLE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   assign get_weights = (r_state == LOAD_W);
   assign draw        = (r_state == DISPLAY);
   assign fp_go       = r_fp_go;
   assign bp_go       = r_bp_go;
   assign upd_go      = r_upd_go;
   assign layer_idx   = r_layer;
   assign sample_cnt  = r_cnt;
   assign busy        = w_busy;
   assign image_out   = r_image;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench: 3-layer/batch-2 instance for the main flows, 1-layer/batch-1 instance for the degenerate build.
`timescale 1ns/1ps
module tb_nn_layer_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   always #5 clk = ~clk;

   // 3-layer, batch-2 instance
   logic        start, train, abort, weights_ack, fp_done, bp_done, upd_done, drawn;
   logic [15:0] image_in;
   logic        get_weights, fp_go, bp_go, upd_go, draw, busy, overrun;
   logic [1:0]  layer_idx;
   logic [1:0]  sample_cnt;
   logic [15:0] image_out;

   // 1-layer, batch-1 instance
   logic        b_start, b_train, b_abort, b_weights_ack, b_fp_done, b_bp_done, b_upd_done, b_drawn;
   logic [15:0] b_image_in;
   logic        b_get_weights, b_fp_go, b_bp_go, b_upd_go, b_draw, b_busy, b_overrun;
   logic [0:0]  b_layer_idx;
   logic [0:0]  b_sample_cnt;
   logic [15:0] b_image_out;

   int n_checks = 0;
   int n_pass   = 0;
   int b_fp_cnt = 0, b_bp_cnt = 0, b_upd_cnt = 0;

   nn_layer_sequencer #(.IMG_SZ(16), .NUM_LAYERS(3), .BATCH_SZ(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .train(train), .abort(abort),
      .image_in(image_in), .weights_ack(weights_ack), .fp_done(fp_done),
      .bp_done(bp_done), .upd_done(upd_done), .drawn(drawn),
      .get_weights(get_weights), .fp_go(fp_go), .bp_go(bp_go), .upd_go(upd_go),
      .draw(draw), .layer_idx(layer_idx), .sample_cnt(sample_cnt), .busy(busy),
      .overrun(overrun), .image_out(image_out)
   );

   nn_layer_sequencer #(.IMG_SZ(16), .NUM_LAYERS(1), .BATCH_SZ(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(b_start), .train(b_train), .abort(b_abort),
      .image_in(b_image_in), .weights_ack(b_weights_ack), .fp_done(b_fp_done),
      .bp_done(b_bp_done), .upd_done(b_upd_done), .drawn(b_drawn),
      .get_weights(b_get_weights), .fp_go(b_fp_go), .bp_go(b_bp_go), .upd_go(b_upd_go),
      .draw(b_draw), .layer_idx(b_layer_idx), .sample_cnt(b_sample_cnt), .busy(b_busy),
      .overrun(b_overrun), .image_out(b_image_out)
   );

   always @(posedge clk) begin
      if (b_fp_go)  b_fp_cnt  <= b_fp_cnt + 1;
      if (b_bp_go)  b_bp_cnt  <= b_bp_cnt + 1;
      if (b_upd_go) b_upd_cnt <= b_upd_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic startp(input logic [15:0] img, input logic tr);
      image_in = img; train = tr; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic ackw(); weights_ack = 1'b1; tick(); weights_ack = 1'b0; endtask
   task automatic fpd();  fp_done     = 1'b1; tick(); fp_done     = 1'b0; endtask
   task automatic bpd();  bp_done     = 1'b1; tick(); bp_done     = 1'b0; endtask
   task automatic updd(); upd_done    = 1'b1; tick(); upd_done    = 1'b0; endtask
   task automatic drw();  drawn       = 1'b1; tick(); drawn       = 1'b0; endtask

   initial begin
      rst_n = 1'b0;
      {start, train, abort, weights_ack, fp_done, bp_done, upd_done, drawn} = '0;
      image_in = '0;
      {b_start, b_train, b_abort, b_weights_ack, b_fp_done, b_bp_done, b_upd_done, b_drawn} = '0;
      b_image_in = 16'h1234;
      tick(); tick();
      chk("rst_outs", {get_weights, fp_go, bp_go, upd_go, draw, busy, overrun}, 0);
      chk("rst_layer", layer_idx, 0);
      chk("rst_cnt", sample_cnt, 0);
      chk("rst_img", image_out, 0);
      rst_n = 1'b1;
      tick();

      // inference with initial weight load
      startp(16'hA1A1, 1'b0);
      chk("t1_getw", {get_weights, fp_go}, 2'b10);
      chk("t1_img", image_out, 16'hA1A1);
      tick();
      chk("t1_getw_hold", get_weights, 1);
      ackw();
      chk("t1_fp0", {get_weights, fp_go, layer_idx}, {1'b0, 1'b1, 2'd0});
      tick();
      chk("t1_fp_pulse", fp_go, 0);
      fpd();
      chk("t1_fp1", {fp_go, layer_idx}, {1'b1, 2'd1});
      fpd();
      chk("t1_fp2", {fp_go, layer_idx}, {1'b1, 2'd2});
      fpd();
      chk("t1_draw", {draw, fp_go, bp_go}, 3'b100);
      tick();
      chk("t1_draw_hold", draw, 1);
      drw();
      chk("t1_idle", {busy, draw}, 0);
      startp(16'hB2B2, 1'b0);
      chk("t1_fast_fp", {fp_go, get_weights, layer_idx}, {1'b1, 1'b0, 2'd0});
      fpd(); fpd(); fpd();
      chk("t1b_draw", draw, 1);
      drw();

      // training sample 1
      startp(16'hC3C3, 1'b1);
      chk("t2_s1_fp", {fp_go, get_weights}, 2'b10);
      fpd(); fpd(); fpd();
      chk("t2_bp2", {bp_go, layer_idx, fp_go, draw}, {1'b1, 2'd2, 1'b0, 1'b0});
      bpd();
      chk("t2_bp1", {bp_go, layer_idx}, {1'b1, 2'd1});
      bpd();
      chk("t2_bp0", {bp_go, layer_idx}, {1'b1, 2'd0});
      bpd();
      chk("t2_s1_done", {busy, upd_go, sample_cnt}, {1'b0, 1'b0, 2'd1});

      // abort in BWD at layer 1 with a simultaneous bp_done
      startp(16'hF6F6, 1'b1);
      fpd(); fpd(); fpd(); bpd();
      chk("t4_bp1", {bp_go, layer_idx}, {1'b1, 2'd1});
      abort = 1'b1; bp_done = 1'b1;
      tick();
      abort = 1'b0; bp_done = 1'b0;
      chk("t4_idle", {busy, bp_go, upd_go}, 0);
      chk("t4_cnt", sample_cnt, 1);
      tick();
      chk("t4_stay_idle", busy, 0);

      // training sample 2 completes the batch
      startp(16'hD4D4, 1'b1);
      chk("t2_s2_noload", {fp_go, get_weights}, 2'b10);
      fpd(); fpd(); fpd(); bpd(); bpd(); bpd();
      chk("t2_upd", {upd_go, busy, sample_cnt}, {1'b1, 1'b1, 2'd2});
      tick();
      chk("t2_upd_pulse", upd_go, 0);
      updd();
      chk("t2_upd_done", {busy, sample_cnt}, 0);

      // stale weights reload, then queueing and overrun
      startp(16'hE5E5, 1'b0);
      chk("t3_reload", {get_weights, fp_go}, 2'b10);
      ackw();
      chk("t3_fp0", fp_go, 1);
      startp(16'hB0B0, 1'b0);
      chk("t3_queued_img", image_out, 16'hE5E5);
      chk("t3_no_overrun", {overrun, busy}, 2'b01);
      startp(16'hC0C0, 1'b1);
      chk("t3_overrun", overrun, 1);
      tick();
      chk("t3_overrun_pulse", overrun, 0);
      fpd(); fpd(); fpd();
      chk("t3_a_draw", draw, 1);
      drw();
      chk("t3_a_idle", busy, 0);
      tick();
      chk("t3_b_accept", {busy, fp_go, layer_idx}, {1'b1, 1'b1, 2'd0});
      chk("t3_b_img", image_out, 16'hB0B0);
      fpd(); fpd(); fpd();
      chk("t3_b_infer", {draw, bp_go}, 2'b10);
      drw(); tick();
      chk("t3_c_dropped", busy, 0);

      // async reset mid-FWD
      startp(16'h7777, 1'b0);
      fpd();
      chk("t5_fp1", {fp_go, layer_idx}, {1'b1, 2'd1});
      rst_n = 1'b0;
      #1;
      chk("t5_async_outs", {get_weights, fp_go, bp_go, upd_go, draw, busy, overrun}, 0);
      chk("t5_async_state", {layer_idx, sample_cnt, image_out}, 0);
      tick();
      rst_n = 1'b1;
      tick();
      startp(16'h8888, 1'b0);
      chk("t5_reload", {get_weights, fp_go}, 2'b10);

      // single-layer, batch-1 build
      b_train = 1'b1; b_start = 1'b1;
      tick();
      b_start = 1'b0;
      chk("t6_getw", {b_get_weights, b_layer_idx}, 2'b10);
      b_weights_ack = 1'b1; tick(); b_weights_ack = 1'b0;
      chk("t6_fp", {b_fp_go, b_bp_go, b_layer_idx}, 3'b100);
      b_fp_done = 1'b1; tick(); b_fp_done = 1'b0;
      chk("t6_bp", {b_bp_go, b_fp_go, b_layer_idx}, 3'b100);
      b_bp_done = 1'b1; tick(); b_bp_done = 1'b0;
      chk("t6_upd", {b_upd_go, b_sample_cnt, b_bp_go, b_layer_idx}, 4'b1100);
      b_upd_done = 1'b1; tick(); b_upd_done = 1'b0;
      chk("t6_done", {b_busy, b_sample_cnt, b_layer_idx}, 0);
      tick();
      chk("t6_pulse_counts", {b_fp_cnt[3:0], b_bp_cnt[3:0], b_upd_cnt[3:0]}, 12'h111);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
